// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants, fill-state type and sizing helper for the sequence detector
package seq_det_pkg;
    localparam int PAT_LEN_MAX = 16;
    localparam logic [3:0] PAT_RST_DEF = 4'b0101;
    localparam int CNT_W_DEF = 8;
    typedef enum logic {FILLING, FULL} fill_state_e;
    function automatic int fill_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction
endpackage

// File: rtl/sd_sat_counter.sv
// sd_sat_counter: saturating up-counter where clear beats increment
module sd_sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    // count up to all-ones and hold there; clear wins over increment
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) q <= '0;
        else if (clr) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with runtime pattern, overlap mode and match counter
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(PAT_RST_DEF),
    parameter int                 CNT_W   = CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               EN,
    input  logic               X,
    input  logic               PAT_LD,
    input  logic [PAT_LEN-1:0] PAT_IN,
    input  logic               OVERLAP,
    input  logic               CLR_CNT,
    output logic               F,
    output logic [CNT_W-1:0]   MATCH_CNT,
    output logic               BUSY
);
    localparam int FW = fill_w(PAT_LEN);
    localparam logic [FW-1:0] FULLV = FW'(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
        $error("PAT_LEN out of range");
    end

    logic [PAT_LEN-1:0] pat_q, pat_d, win_q, win_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               f_q, match;
    fill_state_e        state;

    assign state = (fill_q == FULLV) ? FULL : FILLING;
    assign BUSY  = (fill_q != '0) && (state == FILLING);
    assign F     = f_q;

    // pattern, window and fill registers plus the one-cycle match pulse
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            pat_q  <= PAT_RST;
            win_q  <= '0;
            fill_q <= '0;
            f_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            win_q  <= win_d;
            fill_q <= fill_d;
            f_q    <= match;
        end

    // next state: a load wipes the window; otherwise shift on EN and judge the match on the new window
    always_comb begin
        pat_d  = pat_q;
        win_d  = win_q;
        fill_d = fill_q;
        match  = 1'b0;
        if (PAT_LD) begin
            pat_d  = PAT_IN;
            win_d  = '0;
            fill_d = '0;
        end else if (EN) begin
            win_d  = {win_q[PAT_LEN-2:0], X};
            fill_d = (state == FULL) ? fill_q : fill_q + FW'(1);
            match  = (fill_d == FULLV) && (win_d == pat_q);
            if (match && !OVERLAP) fill_d = '0;
        end
    end

    sd_sat_counter #(.W(CNT_W)) u_cnt (
        .CLK  (CLK),
        .RST_N(RST_N),
        .inc  (match),
        .clr  (CLR_CNT),
        .q    (MATCH_CNT)
    );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed scoreboard bench for the default and a 2-bit-counter detector
module tb_seq_detector_param;
    logic       CLK = 0, RST_N = 0, EN = 0, X = 0, PAT_LD = 0, OVERLAP = 0, CLR_CNT = 0;
    logic [3:0] PAT_IN = '0;
    logic       F, F2, BUSY, BUSY2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    typedef struct {string tag; logic f;} exp_t;
    exp_t exp_q[$];
    int passes = 0, total = 0;

    seq_detector_param dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .X(X), .PAT_LD(PAT_LD), .PAT_IN(PAT_IN),
        .OVERLAP(OVERLAP), .CLR_CNT(CLR_CNT), .F(F), .MATCH_CNT(cnt8), .BUSY(BUSY)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .X(X), .PAT_LD(PAT_LD), .PAT_IN(PAT_IN),
        .OVERLAP(OVERLAP), .CLR_CNT(CLR_CNT), .F(F2), .MATCH_CNT(cnt2), .BUSY(BUSY2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_cnt(input string tag, input int e8, input int e2);
        chk({tag, "_cnt8"}, 32'(cnt8), e8);
        chk({tag, "_cnt2"}, 32'(cnt2), e2);
    endtask

    task automatic chk_busy(input string tag, input logic eb);
        chk({tag, "_busy"}, 32'(BUSY), 32'(eb));
        chk({tag, "_busy2"}, 32'(BUSY2), 32'(eb));
    endtask

    task automatic bit_step(input logic en, input logic x, input logic ef, input string tag);
        exp_t e;
        EN = en;
        X  = x;
        e.tag = tag;
        e.f   = ef;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, "_f"}, 32'(F), 32'(e.f));
        chk({e.tag, "_f2"}, 32'(F2), 32'(e.f));
        EN = 0;
        CLR_CNT = 0;
    endtask

    task automatic load(input logic [3:0] p, input logic clr, input string tag);
        PAT_LD  = 1;
        PAT_IN  = p;
        CLR_CNT = clr;
        bit_step(1, 1, 0, tag);
        PAT_LD = 0;
        chk_busy(tag, 0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1;
        chk("rst_f", 32'(F), 0);
        chk_cnt("rst", 0, 0);
        chk_busy("rst", 0);
        for (int i = 0; i < 10; i++) bit_step(0, 1'($urandom), 0, "idle");

        OVERLAP = 1;
        for (int i = 0; i < 8; i++) begin
            bit_step(1, 1'(i & 1), (i == 3 || i == 5 || i == 7), "ovl");
            chk_busy("ovl", i < 3);
        end
        chk_cnt("ovl", 3, 3);

        load(4'b0101, 1, "ld_novl");
        chk_cnt("ld_novl", 0, 0);
        OVERLAP = 0;
        for (int i = 0; i < 8; i++) begin
            bit_step(1, 1'(i & 1), (i == 3 || i == 7), "novl");
            chk_busy("novl", (i % 4) != 3);
        end
        chk_cnt("novl", 2, 2);

        load(4'b1100, 0, "ld_1100");
        for (int i = 0; i < 4; i++) begin
            bit_step(1, i < 2, i == 3, "enb");
            if (i < 3) bit_step(0, !(i < 2), 0, "gap");
        end
        chk_cnt("enb", 3, 3);

        load(4'b0101, 1, "ld_sat");
        OVERLAP = 1;
        for (int i = 0; i < 12; i++) begin
            bit_step(1, 1'(i & 1), (i >= 3) && (i & 1) == 1, "sat");
            if (i >= 3 && (i & 1) == 1)
                chk_cnt("sat", (i - 1) / 2, ((i - 1) / 2 > 3) ? 3 : (i - 1) / 2);
        end
        bit_step(1, 0, 0, "sat_gap");
        CLR_CNT = 1;
        bit_step(1, 1, 1, "clr_match");
        chk_cnt("clr_match", 0, 0);

        load(4'b1100, 0, "ld_mid");
        bit_step(1, 1, 0, "mid");
        bit_step(1, 1, 0, "mid");
        bit_step(1, 0, 0, "mid");
        chk_busy("mid", 1);
        #2;
        RST_N = 0;
        #3;
        chk("arst_f", 32'(F), 0);
        chk_busy("arst", 0);
        #1;
        RST_N = 1;
        bit_step(1, 0, 0, "post0");
        chk_busy("post0", 1);
        bit_step(1, 1, 0, "post1");
        bit_step(1, 0, 0, "post2");
        bit_step(1, 1, 1, "post3");
        chk_cnt("post", 1, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
